// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle arithmetic/logic, bit-serial shifts, optional iterative multiply.
// Optional feature macro: ALU_EXEC_MUL_EN enables the shift-add multiplier (Func7 01h in R-type).
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      Func3,
  input  logic [6:0]      Func7,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            Illegal
);

  localparam int CW = SHW + 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } op_e;

`ifdef ALU_EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
`endif

  state_e          r_state, w_next;
  op_e             w_op, r_shOp;
  logic [XLEN-1:0] r_result, r_acc, w_aluOut, w_shStep;
  logic            r_illegal;
  logic [CW-1:0]   r_cnt, w_amt;
  logic            w_accept, w_isShift;
`ifdef ALU_EXEC_MUL_EN
  logic [XLEN-1:0] r_mcand, r_mplier, w_mulAcc;
`endif

  assign w_amt     = {1'b0, B[SHW-1:0]};
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_isShift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

  always_comb begin
    w_op = OP_ILL;
    case (ALUOp)
      2'b00: w_op = OP_ADD;
      2'b01: begin
        case (Func7)
          7'h00: begin
            case (Func3)
              3'd0: w_op = OP_ADD;
              3'd1: w_op = OP_SLL;
              3'd2: w_op = OP_SLT;
              3'd3: w_op = OP_SLTU;
              3'd4: w_op = OP_XOR;
              3'd5: w_op = OP_SRL;
              3'd6: w_op = OP_OR;
              default: w_op = OP_AND;
            endcase
          end
          7'h20: begin
            if (Func3 == 3'd0) w_op = OP_SUB;
            else if (Func3 == 3'd5) w_op = OP_SRA;
          end
`ifdef ALU_EXEC_MUL_EN
          7'h01: w_op = OP_MUL;
`endif
          default: w_op = OP_ILL;
        endcase
      end
      2'b10: begin
        case (Func3)
          3'd0: w_op = OP_ADD;
          3'd1: w_op = OP_SLL;
          3'd2: w_op = OP_SLT;
          3'd3: w_op = OP_SLTU;
          3'd4: w_op = OP_XOR;
          3'd5: begin
            if (Func7 == 7'h00) w_op = OP_SRL;
            else if (Func7 == 7'h20) w_op = OP_SRA;
          end
          3'd6: w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      default: begin
        case (Func3)
          3'd0, 3'd1: w_op = OP_SUB;
          3'd4, 3'd5: w_op = OP_SLT;
          3'd6, 3'd7: w_op = OP_SLTU;
          default:    w_op = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle results; illegal ops fall through to zero
  always_comb begin
    w_aluOut = '0;
    case (w_op)
      OP_ADD:  w_aluOut = A + B;
      OP_SUB:  w_aluOut = A - B;
      OP_SLT:  w_aluOut = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_aluOut = {{(XLEN-1){1'b0}}, (A < B)};
      OP_XOR:  w_aluOut = A ^ B;
      OP_OR:   w_aluOut = A | B;
      OP_AND:  w_aluOut = A & B;
      default: w_aluOut = '0;
    endcase
  end

  always_comb begin
    w_shStep = r_acc >> 1;
    case (r_shOp)
      OP_SLL:  w_shStep = r_acc << 1;
      OP_SRA:  w_shStep = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
      default: w_shStep = r_acc >> 1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  assign w_mulAcc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_isShift && (w_amt != '0)) w_next = S_SHIFT;
`ifdef ALU_EXEC_MUL_EN
          else if (w_op == OP_MUL)        w_next = S_MUL;
`endif
          else                            w_next = S_DONE;
        end
      end
      S_SHIFT: if (r_cnt == CW'(1)) w_next = S_DONE;
`ifdef ALU_EXEC_MUL_EN
      S_MUL:   if (r_cnt == CW'(1)) w_next = S_DONE;
`endif
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result is written only on the transition into DONE; r_acc holds work in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_shOp    <= OP_SLL;
`ifdef ALU_EXEC_MUL_EN
      r_mcand   <= '0;
      r_mplier  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_isShift) begin
              r_acc  <= A;
              r_cnt  <= w_amt;
              r_shOp <= w_op;
              if (w_amt == '0) begin
                r_result  <= A;
                r_illegal <= 1'b0;
              end
            end
`ifdef ALU_EXEC_MUL_EN
            else if (w_op == OP_MUL) begin
              r_acc    <= '0;
              r_mcand  <= A;
              r_mplier <= B;
              r_cnt    <= CW'(XLEN);
            end
`endif
            else begin
              r_result  <= w_aluOut;
              r_illegal <= (w_op == OP_ILL);
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_shStep;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result  <= w_shStep;
            r_illegal <= 1'b0;
          end
        end
`ifdef ALU_EXEC_MUL_EN
        S_MUL: begin
          r_acc    <= w_mulAcc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result  <= w_mulAcc;
            r_illegal <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Result    = r_result;
  assign Zero      = (r_result == '0);
  assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32): directed vectors plus randomized ops against a behavioural model.
// Follows the ALU_EXEC_MUL_EN macro so expectations match the build configuration.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      Func3;
  logic [6:0]      Func7;
  logic [XLEN-1:0] A, B, Result;
  logic            Zero, Illegal;

  int total  = 0;
  int passed = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Func3(Func3), .Func7(Func7), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected result, illegal flag and latency from the instruction-level rules
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    ill = 1'b0;
    lat = 1;
    case (op)
      2'b00: r = a + b;
      2'b01: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: r = a + b;
            3'd1: begin r = a << sh; lat = sh + 1; end
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin r = a >> sh; lat = sh + 1; end
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          r = a - b;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          r = $unsigned($signed(a) >>> sh); lat = sh + 1;
        end else if (f7 == 7'h01) begin
`ifdef ALU_EXEC_MUL_EN
          r = a * b; lat = XLEN + 1;
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      2'b10: begin
        case (f3)
          3'd0: r = a + b;
          3'd1: begin r = a << sh; lat = sh + 1; end
          3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: r = (a < b) ? 32'd1 : 32'd0;
          3'd4: r = a ^ b;
          3'd5: begin
            if (f7 == 7'h00)      begin r = a >> sh; lat = sh + 1; end
            else if (f7 == 7'h20) begin r = $unsigned($signed(a) >>> sh); lat = sh + 1; end
            else ill = 1'b1;
          end
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
      default: begin
        if (f3 == 3'd0 || f3 == 3'd1)      r = a - b;
        else if (f3 == 3'd4 || f3 == 3'd5) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (f3 == 3'd6 || f3 == 3'd7) r = (a < b) ? 32'd1 : 32'd0;
        else ill = 1'b1;
      end
    endcase
    if (ill) r = 32'd0;
  endfunction

  // Issues one request and waits (bounded) for out_valid; returns observations at that negedge
  task automatic runOp(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic zr, output logic il,
                       output bit timedOut, output int busyErr);
    logic [31:0] startRes;
    @(negedge clk);
    startRes = Result;
    ALUOp = op; Func3 = f3; Func7 = f7; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUOp = 2'($urandom); Func3 = 3'($urandom); Func7 = 7'($urandom); A = $urandom; B = $urandom;
    lat = 0; timedOut = 1'b0; busyErr = 0;
    forever begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (in_ready || Result !== startRes) busyErr++;
      if (lat >= 100) begin timedOut = 1'b1; break; end
    end
    res = Result; zr = Zero; il = Illegal;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1)  $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);   else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (Result !== 32'd0)   $display("[TB] FAIL reset_result: got %h expected 0", Result);       else passed++;
    total++; if (Zero !== 1'b1)      $display("[TB] FAIL reset_zero: got %b expected 1", Zero);           else passed++;
    total++; if (Illegal !== 1'b0)   $display("[TB] FAIL reset_illegal: got %b expected 0", Illegal);     else passed++;
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    int lat, be; logic [31:0] res; logic zr, il; bit tmo;
    runOp(2'b01, 3'd0, 7'h20, 32'd5, 32'd7, lat, res, zr, il, tmo, be);
    total++; if (res !== 32'hFFFFFFFE) $display("[TB] FAIL sub_result: got %h expected fffffffe", res); else passed++;
    total++; if (zr !== 1'b0)          $display("[TB] FAIL sub_zero: got %b expected 0", zr);           else passed++;
    total++; if (lat !== 1 || tmo)     $display("[TB] FAIL sub_latency: got %0d expected 1", lat);      else passed++;
    retire();
    runOp(2'b11, 3'd4, 7'h00, 32'hFFFFFFFF, 32'd1, lat, res, zr, il, tmo, be);
    total++; if (res !== 32'd1) $display("[TB] FAIL br_slt: got %h expected 1", res); else passed++;
    retire();
    runOp(2'b11, 3'd6, 7'h00, 32'hFFFFFFFF, 32'd1, lat, res, zr, il, tmo, be);
    total++; if (res !== 32'd0 || zr !== 1'b1) $display("[TB] FAIL br_sltu: got %h zero %b expected 0 zero 1", res, zr); else passed++;
    retire();
    runOp(2'b01, 3'd5, 7'h20, 32'h80000000, 32'd4, lat, res, zr, il, tmo, be);
    total++; if (res !== 32'hF8000000) $display("[TB] FAIL sra_result: got %h expected f8000000", res); else passed++;
    total++; if (lat !== 5 || tmo)     $display("[TB] FAIL sra_latency: got %0d expected 5", lat);      else passed++;
    total++; if (be !== 0)             $display("[TB] FAIL sra_busy: got %0d bad busy cycles expected 0", be); else passed++;
    retire();
    runOp(2'b10, 3'd1, 7'h00, 32'h00001234, 32'hFFFFFFE0, lat, res, zr, il, tmo, be);
    total++; if (res !== 32'h1234 || lat !== 1) $display("[TB] FAIL shift0: got %h lat %0d expected 1234 lat 1", res, lat); else passed++;
    retire();
    runOp(2'b11, 3'd2, 7'h00, 32'd9, 32'd3, lat, res, zr, il, tmo, be);
    total++; if (il !== 1'b1 || res !== 32'd0 || lat !== 1)
      $display("[TB] FAIL br_illegal: got il %b res %h lat %0d expected il 1 res 0 lat 1", il, res, lat); else passed++;
    retire();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL post_retire: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_mul_hold();
    int lat, be; logic [31:0] res; logic zr, il; bit tmo;
    runOp(2'b01, 3'd0, 7'h01, 32'd3, 32'hFFFFFFFF, lat, res, zr, il, tmo, be);
`ifdef ALU_EXEC_MUL_EN
    total++; if (res !== 32'hFFFFFFFD) $display("[TB] FAIL mul_result: got %h expected fffffffd", res); else passed++;
    total++; if (lat !== 33 || tmo)    $display("[TB] FAIL mul_latency: got %0d expected 33", lat);     else passed++;
    total++; if (be !== 0)             $display("[TB] FAIL mul_busy: got %0d bad busy cycles expected 0", be); else passed++;
    in_valid = 1'b1; ALUOp = 2'b00; A = 32'd1; B = 32'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || Result !== 32'hFFFFFFFD)
        $display("[TB] FAIL mul_hold: got valid %b res %h expected 1 fffffffd", out_valid, Result); else passed++;
    end
    in_valid = 1'b0;
    retire();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL mul_release: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); else passed++;
`else
    total++; if (il !== 1'b1 || res !== 32'd0 || lat !== 1)
      $display("[TB] FAIL mul_disabled: got il %b res %h lat %0d expected il 1 res 0 lat 1", il, res, lat); else passed++;
    retire();
`endif
  endtask

  task automatic test_back_to_back();
    int lat, be; logic [31:0] res; logic zr, il; bit tmo;
    runOp(2'b00, 3'd0, 7'h00, 32'd10, 32'd20, lat, res, zr, il, tmo, be);
    total++; if (res !== 32'd30) $display("[TB] FAIL b2b_first: got %h expected 1e", res); else passed++;
    ALUOp = 2'b01; Func3 = 3'd0; Func7 = 7'h20; A = 32'd50; B = 32'd8; in_valid = 1'b1;
    retire();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL b2b_no_accept_in_done: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || Result !== 32'd42)
      $display("[TB] FAIL b2b_second: got valid %b res %h expected 1 2a", out_valid, Result); else passed++;
    retire();
  endtask

  task automatic test_reset_mid_op();
    int lat, be; logic [31:0] res; logic zr, il; bit tmo;
    runOp(2'b00, 3'd0, 7'h00, 32'd1, 32'd1, lat, res, zr, il, tmo, be);
    retire();
    @(negedge clk);
`ifdef ALU_EXEC_MUL_EN
    ALUOp = 2'b01; Func3 = 3'd0; Func7 = 7'h01; A = 32'd7; B = 32'd9;
`else
    ALUOp = 2'b01; Func3 = 3'd1; Func7 = 7'h00; A = 32'd7; B = 32'd25;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL midreset_handshake: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); else passed++;
    total++; if (Result !== 32'd0 || Zero !== 1'b1 || Illegal !== 1'b0)
      $display("[TB] FAIL midreset_result: got res %h zero %b ill %b expected 0 1 0", Result, Zero, Illegal); else passed++;
    @(negedge clk);
    rst = 1'b0;
    ALUOp = 2'b00; Func3 = 3'd0; Func7 = 7'h00; A = 32'd2; B = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || Result !== 32'd4)
      $display("[TB] FAIL post_reset_add: got valid %b res %h expected 1 4", out_valid, Result); else passed++;
    retire();
  endtask

  task automatic test_random();
    int lat, be, expLat; logic [31:0] res, expRes, a, b; logic zr, il, expIl; bit tmo;
    logic [1:0] op; logic [2:0] f3; logic [6:0] f7;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      if (op == 2'b10 && f3 == 3'd1) f7 = 7'h00;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? {27'd0, 5'($urandom)} : $urandom;
      if (i % 8 == 3) b = a;
      model(op, f3, f7, a, b, expRes, expIl, expLat);
      runOp(op, f3, f7, a, b, lat, res, zr, il, tmo, be);
      total++; if (res !== expRes) $display("[TB] FAIL rnd%0d_result op %b f3 %0d f7 %h: got %h expected %h", i, op, f3, f7, res, expRes); else passed++;
      total++; if (il !== expIl)   $display("[TB] FAIL rnd%0d_illegal: got %b expected %b", i, il, expIl); else passed++;
      total++; if (zr !== (expRes == 32'd0)) $display("[TB] FAIL rnd%0d_zero: got %b expected %b", i, zr, (expRes == 32'd0)); else passed++;
      total++; if (lat !== expLat || tmo) $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, lat, expLat); else passed++;
      total++; if (be !== 0) $display("[TB] FAIL rnd%0d_busy: got %0d bad busy cycles expected 0", i, be); else passed++;
      retire();
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = 2'b00; Func3 = 3'd0; Func7 = 7'h00; A = '0; B = '0;
    test_reset();
    test_spec_vectors();
    test_mul_hold();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 ALUOp  input  2  00 load/store, 01 R-type, 10 I-type, 11 branch.
REQ-008 Func3  input  3  instruction funct3.
REQ-009 Func7  input  7  instruction funct7.
REQ-010 A, B  input  XLEN each  operands.
REQ-011 out_valid  output  1  Result valid.
REQ-012 out_ready  input  1  consumer accepts Result.
REQ-013 Result  output  XLEN  operation result.
REQ-014 Zero  output  1  Result == 0.
REQ-015 Illegal  output  1  decode had no legal op; qualified by out_valid.

Function
REQ-016 Request accepted on a clk edge where in_valid && in_ready; ALUOp/Func3/Func7/A/B captured then and ignored afterwards.
REQ-017 Decode ALUOp 00: ADD.
REQ-018 Decode ALUOp 01: Func7 01h -> MUL (config dependent); Func7 20h with Func3 0 -> SUB, Func3 5 -> SRA; Func7 00h with Func3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND; anything else illegal.
REQ-019 Decode ALUOp 10: Func3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND, 1 SLL, 5 SRL (Func7 00h) or SRA (Func7 20h); anything else illegal.
REQ-020 Decode ALUOp 11: Func3 0/1 SUB, 4/5 SLT, 6/7 SLTU, 2/3 illegal.
REQ-021 Illegal op: Result = 0, Illegal = 1, latency 1.
REQ-022 Arithmetic modulo 2^XLEN; SLT signed, SLTU unsigned, result 1 or 0 zero-extended; shift amount = B[SHW-1:0].
REQ-023 FSM states IDLE, SHIFT, MUL, DONE; in_ready = 1 only in IDLE.
REQ-024 IDLE: accepted ADD/SUB/logic/compare/illegal -> DONE with Result registered; latency 1 cycle.
REQ-025 IDLE: accepted shift with amount 0 -> DONE, Result = A; amount n>0 -> SHIFT, one bit position per cycle, -> DONE after n cycles (latency n+1).
REQ-026 IDLE: accepted MUL -> MUL, iterative shift-add one multiplier bit per cycle, low XLEN product bits, -> DONE after XLEN cycles (latency XLEN+1).
REQ-027 DONE: out_valid = 1, Result/Zero/Illegal held stable until out_ready; out_valid && out_ready -> IDLE; no new request accepted in the same cycle.
REQ-028 out_valid = 0 in IDLE, SHIFT, MUL; Result changes only when entering DONE.
REQ-029 in_valid without in_ready is ignored; no queueing.

Reset
REQ-030 rst asserted at any time, including mid-SHIFT/MUL or in DONE, aborts the operation immediately: state IDLE, in_ready 1, out_valid 0, Result 0, Zero 1, Illegal 0.
REQ-031 First request accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-032 Macro ALU_EXEC_MUL_EN defined: MUL decoded and executed per REQ-026.
REQ-033 ALU_EXEC_MUL_EN undefined: MUL state and multiplier datapath absent; Func7 01h in ALUOp 01 decodes illegal per REQ-021.

Verification
REQ-034 XLEN=32; ALUOp 01, Func7 20h, Func3 0, A=5, B=7 -> one cycle later out_valid, Result FFFFFFFEh, Zero 0.
REQ-035 ALUOp 11, Func3 4, A=FFFFFFFFh, B=1 -> Result 1; same with Func3 6 -> Result 0.
REQ-036 ALUOp 01, Func7 20h, Func3 5, A=80000000h, B=4 -> in_ready low 4 cycles, out_valid on cycle 5, Result F8000000h.
REQ-037 ALU_EXEC_MUL_EN defined, Func7 01h, A=3, B=FFFFFFFFh, out_ready held 0 -> out_valid on cycle 33, Result FFFFFFFDh held until out_ready pulse, then in_ready 1 next cycle; undefined -> Illegal 1, Result 0 after 1 cycle.
REQ-038 rst pulsed during MUL cycle 10 -> out_valid 0, Result 0, in_ready 1 immediately; next ADD A=2, B=2 -> Result 4 after 1 cycle.
REQ-039 ALUOp 10, Func3 1, B[4:0]=0, A=1234h -> Result 1234h latency 1; ALUOp 11, Func3 2 -> Illegal 1.
